// File: rtl/nios2_ocimem_pkg.sv
// Shared types and constants for the Nios II debug-slave on-chip memory.
// Holds the FSM encoding and the jdo payload field positions.
package nios2_ocimem_pkg;

    localparam int OCI_ADDR_W = 8;
    localparam int RAM_DEPTH  = 1 << OCI_ADDR_W;

    localparam int JDO_ADDR_LSB = 2;
    localparam int JDO_WD_LSB   = 3;
    localparam int JDO_WD_MSB   = 34;
    localparam int JDO_RD_FLAG  = 35;

    typedef enum logic [2:0] {
        S_IDLE,
        S_JRD0,
        S_JRD1,
        S_JWR,
        S_CRD
    } ocimem_state_e;

endpackage

// File: rtl/nios2_cpu_debug_slave_ocimem_if.sv
// CPU-side Avalon-MM slave bundle for the debug RAM.
// master drives requests, slave returns data and stall.
interface nios2_cpu_debug_slave_ocimem_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write,
        output avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write,
        input  avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/nios2_cpu_debug_slave_ocimem_ram.sv
// Single-port debug RAM, 1-cycle synchronous read, per-byte writes.
// Contents are intentionally not reset.
module nios2_cpu_debug_slave_ocimem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/nios2_cpu_debug_slave_ocimem.sv
// JTAG-driven debug RAM access with a CPU Avalon slave on the same RAM.
// JTAG strobes always take priority over CPU requests.
module nios2_cpu_debug_slave_ocimem
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = $clog2(RAM_DEPTH),
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [DATA_W-1:0] MonDReg,
    output logic              mon_busy,
    output logic              mon_error,
    nios2_cpu_debug_slave_ocimem_if.slave avs
);
    ocimem_state_e     state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [ADDR_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mon_d_q, mon_d_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_be;
    logic [DATA_W-1:0] ram_wd, ram_q;
    logic [ADDR_W-1:0] jaddr;
    logic              strobe, req, wait_c;
    logic              jdo_unused;

    assign jaddr      = jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
    assign strobe     = take_action_ocimem_a | take_no_action_ocimem_a
                      | take_action_ocimem_b;
    assign req        = avs.avs_read | avs.avs_write;
    assign jdo_unused = ^{jdo[37:36], jdo[1:0]};

    always_comb begin
        state_d  = state_q;
        mon_a_d  = mon_a_q;
        acc_d    = acc_q;
        mon_d_d  = mon_d_q;
        wd_d     = wd_q;
        err_d    = err_q;
        ram_addr = avs.avs_address;
        ram_be   = '0;
        ram_wd   = avs.avs_writedata;
        unique case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    take_action_ocimem_a: begin
                        err_d = 1'b0;
                        if (jdo[JDO_RD_FLAG]) begin
                            acc_d   = jaddr;
                            mon_a_d = jaddr + ADDR_W'(1);
                            state_d = S_JRD0;
                        end else begin
                            mon_a_d = jaddr;
                        end
                    end
                    take_no_action_ocimem_a: begin
                        acc_d   = mon_a_q;
                        mon_a_d = mon_a_q + ADDR_W'(1);
                        state_d = S_JRD0;
                    end
                    take_action_ocimem_b: begin
                        acc_d   = mon_a_q;
                        wd_d    = jdo[JDO_WD_MSB:JDO_WD_LSB];
                        mon_a_d = mon_a_q + ADDR_W'(1);
                        state_d = S_JWR;
                    end
                    default: begin
                        if (avs.avs_write && reset_n) ram_be = avs.avs_byteenable;
                        else if (avs.avs_read) state_d = S_CRD;
                    end
                endcase
            end
            S_JRD0: begin
                ram_addr = acc_q;
                state_d  = S_JRD1;
            end
            S_JRD1: begin
                mon_d_d = ram_q;
                state_d = S_IDLE;
            end
            S_JWR: begin
                ram_addr = acc_q;
                ram_be   = '1;
                ram_wd   = wd_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Strobes outside IDLE are dropped and flagged.
        if (state_q != S_IDLE && strobe) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mon_a_q <= '0;
            acc_q   <= '0;
            mon_d_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mon_a_q <= mon_a_d;
            acc_q   <= acc_d;
            mon_d_q <= mon_d_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        wait_c = req;
        unique case (state_q)
            S_IDLE:  wait_c = strobe ? req : avs.avs_read;
            S_CRD:   wait_c = avs.avs_write;
            default: wait_c = req;
        endcase
        if (!reset_n) wait_c = 1'b1;
    end

    nios2_cpu_debug_slave_ocimem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .addr_i  (ram_addr),
        .be_i    (ram_be),
        .wdata_i (ram_wd),
        .rdata_o (ram_q)
    );

    assign MonDReg             = mon_d_q;
    assign mon_error           = err_q;
    assign mon_busy            = (state_q == S_JRD0) || (state_q == S_JRD1)
                               || (state_q == S_JWR);
    assign avs.avs_waitrequest = wait_c;
    assign avs.avs_readdata    = (state_q == S_CRD) ? ram_q : '0;
endmodule
